jump_predict_unit: RTL and testbench

JUMP_PREDICT_UNIT -- requirements
Module: jump_predict_unit

---
 rtl/jump_pkg.sv | 29 ++
 rtl/jump_predict_unit_if.sv | 55 +++++
 rtl/jump_btb.sv | 67 ++++++
 rtl/jump_predict_unit.sv | 87 ++++++++
 tb/tb_jump_predict_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jump_pkg.sv
// Shared types and constants for the jump predictor: 2-bit counter states,
// the counter reset value and the instruction step.
package jump_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e        CTR_RESET = CTR_WNT;
  localparam int unsigned INSN_STEP = 4;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic ctr_e ctr_next(ctr_e cur, logic taken);
    ctr_e nxt;
    nxt = cur;
    case (cur)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jump_predict_unit_if.sv
// Fetch-side lookup and resolve-side update bus of the jump predictor.
// Optional perf counters appear when JUMP_PREDICT_PERF_EN is defined.
interface jump_predict_unit_if #(
  parameter int unsigned PC_W = 9
);
  logic [PC_W-1:0] fetch_pc;
  logic            pred_taken;
  logic [31:0]     pred_target;

  logic            res_valid;
  logic [PC_W-1:0] res_pc;
  logic [31:0]     res_imm;
  logic [31:0]     res_reg2;
  logic            res_is_reg;
  logic            res_taken;
  logic            res_pred_taken;
  logic [31:0]     res_pred_target;
  logic [31:0]     res_target;
  logic [31:0]     res_pc_four;

  logic            redirect_valid;
  logic [31:0]     redirect_pc;

`ifdef JUMP_PREDICT_PERF_EN
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;

  modport master (
    output fetch_pc, res_valid, res_pc, res_imm, res_reg2, res_is_reg,
           res_taken, res_pred_taken, res_pred_target,
    input  pred_taken, pred_target, res_target, res_pc_four,
           redirect_valid, redirect_pc, perf_branches, perf_mispredicts
  );
  modport slave (
    input  fetch_pc, res_valid, res_pc, res_imm, res_reg2, res_is_reg,
           res_taken, res_pred_taken, res_pred_target,
    output pred_taken, pred_target, res_target, res_pc_four,
           redirect_valid, redirect_pc, perf_branches, perf_mispredicts
  );
`else
  modport master (
    output fetch_pc, res_valid, res_pc, res_imm, res_reg2, res_is_reg,
           res_taken, res_pred_taken, res_pred_target,
    input  pred_taken, pred_target, res_target, res_pc_four,
           redirect_valid, redirect_pc
  );
  modport slave (
    input  fetch_pc, res_valid, res_pc, res_imm, res_reg2, res_is_reg,
           res_taken, res_pred_taken, res_pred_target,
    output pred_taken, pred_target, res_target, res_pc_four,
           redirect_valid, redirect_pc
  );
`endif

endinterface

// File: rtl/jump_btb.sv
// Branch target buffer: direct-mapped entries with one combinational read
// port and one write port that steps counters or allocates on taken misses.
module jump_btb
  import jump_pkg::*;
#(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_hit,
  output ctr_e            rd_ctr,
  output logic [31:0]     rd_target,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [31:0]     wr_target
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag    [DEPTH];
  logic [31:0]      target [DEPTH];
  ctr_e             ctr    [DEPTH];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             wr_hit;
  logic             unused_pc_bits;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[PC_W-1:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[PC_W-1:IDX_W+2];
  assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  // Reads see the registered contents, so a same-cycle write shows up next cycle.
  assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
  assign rd_ctr    = ctr[rd_idx];
  assign rd_target = target[rd_idx];
  assign wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_RESET;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
        if (wr_taken) target[wr_idx] <= wr_target;
      end else if (wr_taken) begin
        valid[wr_idx]  <= 1'b1;
        tag[wr_idx]    <= wr_tag;
        target[wr_idx] <= wr_target;
        ctr[wr_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/jump_predict_unit.sv
// Jump predictor top: BTB lookup, resolve target arithmetic, mispredict
// detection and redirect registers. Perf counters under JUMP_PREDICT_PERF_EN.
module jump_predict_unit
  import jump_pkg::*;
#(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned BTB_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  jump_predict_unit_if.slave  bus
);

  logic        rd_hit;
  ctr_e        rd_ctr;
  logic [31:0] rd_target;
  logic [31:0] res_target;
  logic [31:0] res_pc_four;
  logic        pred_taken;
  logic        mispredict;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  jump_btb #(
    .PC_W  (PC_W),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_pc     (bus.fetch_pc),
    .rd_hit    (rd_hit),
    .rd_ctr    (rd_ctr),
    .rd_target (rd_target),
    .wr_en     (bus.res_valid),
    .wr_pc     (bus.res_pc),
    .wr_taken  (bus.res_taken),
    .wr_target (res_target)
  );

  assign pred_taken      = rd_hit && rd_ctr[1];
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_taken ? rd_target
                                      : 32'(bus.fetch_pc) + 32'(INSN_STEP);

  assign res_target  = bus.res_is_reg ? (bus.res_reg2 + bus.res_imm)
                                      : (32'(bus.res_pc) + bus.res_imm);
  assign res_pc_four = 32'(bus.res_pc) + 32'(INSN_STEP);
  assign bus.res_target  = res_target;
  assign bus.res_pc_four = res_pc_four;

  // A taken branch also mispredicts when it lands somewhere other than predicted.
  assign mispredict = bus.res_valid &&
                      ((bus.res_taken != bus.res_pred_taken) ||
                       (bus.res_taken && (res_target != bus.res_pred_target)));

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= bus.res_taken ? res_target : res_pc_four;
    end
  end

  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;

`ifdef JUMP_PREDICT_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      perf_branches    <= perf_branches + 32'(bus.res_valid);
      perf_mispredicts <= perf_mispredicts + 32'(mispredict);
    end
  end

  assign bus.perf_branches    = perf_branches;
  assign bus.perf_mispredicts = perf_mispredicts;
`endif

endmodule

// File: tb/tb_jump_predict_unit.sv
// Self-checking bench for jump_predict_unit (PC_W=9, BTB_DEPTH=8) with a
// reference BTB model and a redirect scoreboard queue.
module tb_jump_predict_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jump_predict_unit_if #(.PC_W(9)) bus ();

  jump_predict_unit #(.PC_W(9), .BTB_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the buffer contents
  bit          m_valid [8];
  int unsigned m_tag   [8];
  logic [31:0] m_tgt   [8];
  int          m_ctr   [8];
  logic [31:0] m_last_rpc;

  function automatic int unsigned m_idx(logic [8:0] pc);
    return (32'(pc) >> 2) % 8;
  endfunction

  function automatic int unsigned m_tagof(logic [8:0] pc);
    return 32'(pc) >> 5;
  endfunction

  function automatic logic m_pred_taken(logic [8:0] pc);
    int unsigned i;
    i = m_idx(pc);
    return m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(logic [8:0] pc);
    return m_pred_taken(pc) ? m_tgt[m_idx(pc)] : 32'(pc) + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_last_rpc = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one resolve, update the model and push the expected redirect.
  task automatic drive_res(input logic [8:0] pc, input logic [31:0] imm,
                           input logic [31:0] reg2, input logic is_reg,
                           input logic taken, input logic ptaken,
                           input logic [31:0] ptgt);
    logic [31:0] tgt;
    logic        mis;
    int unsigned i;
    exp_t        e;
    bus.res_valid       = 1'b1;
    bus.res_pc          = pc;
    bus.res_imm         = imm;
    bus.res_reg2        = reg2;
    bus.res_is_reg      = is_reg;
    bus.res_taken       = taken;
    bus.res_pred_taken  = ptaken;
    bus.res_pred_target = ptgt;
    tgt = is_reg ? reg2 + imm : 32'(pc) + imm;
    mis = (taken != ptaken) || (taken && (tgt != ptgt));
    if (reset) begin
      m_reset();
      e = '{v: 1'b0, pc: 32'h0};
    end else begin
      if (mis) m_last_rpc = taken ? tgt : 32'(pc) + 32'd4;
      e = '{v: mis, pc: m_last_rpc};
      i = m_idx(pc);
      if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
        if (taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(pc);
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fetch_pc = 9'h040;
    bus.res_valid = 1'b0;
    bus.res_pc = '0; bus.res_imm = '0; bus.res_reg2 = '0;
    bus.res_is_reg = 1'b0; bus.res_taken = 1'b0;
    bus.res_pred_taken = 1'b0; bus.res_pred_target = '0;
    m_reset();
    step(); step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_redirect: got v=%0b pc=%h, want v=0 pc=0", bus.redirect_valid, bus.redirect_pc);
    end
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h44) begin
      errors++;
      $display("FAIL reset_pred: got t=%0b tgt=%h, want t=0 tgt=44", bus.pred_taken, bus.pred_target);
    end
  endtask

  task automatic test_alloc();
    exp_t e;
    drive_res(9'h040, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.res_target !== 32'h60 || bus.res_pc_four !== 32'h44) begin
      errors++;
      $display("FAIL alloc_arith: got tgt=%h pc4=%h, want 60 44", bus.res_target, bus.res_pc_four);
    end
    step();
    bus.res_valid = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (bus.redirect_valid !== e.v || bus.redirect_pc !== e.pc || e.pc !== 32'h60) begin
      errors++;
      $display("FAIL alloc_redirect: got v=%0b pc=%h, want v=%0b pc=%h", bus.redirect_valid, bus.redirect_pc, e.v, e.pc);
    end
    bus.fetch_pc = 9'h040;
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h60) begin
      errors++;
      $display("FAIL alloc_pred: got t=%0b tgt=%h, want t=1 tgt=60", bus.pred_taken, bus.pred_target);
    end
  endtask

  task automatic test_reg_target();
    exp_t e;
    drive_res(9'h084, 32'hFFFF_FFFC, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100);
    #1;
    checks++;
    if (bus.res_target !== 32'hFC) begin
      errors++;
      $display("FAIL reg_arith: got %h, want fc", bus.res_target);
    end
    step();
    e = sb_q.pop_front();
    checks++;
    if (bus.redirect_valid !== e.v || bus.redirect_pc !== e.pc || e.pc !== 32'hFC) begin
      errors++;
      $display("FAIL reg_redirect: got v=%0b pc=%h, want v=%0b pc=%h", bus.redirect_valid, bus.redirect_pc, e.v, e.pc);
    end
    // Correctly predicted: no pulse, redirect_pc holds
    drive_res(9'h084, 32'hFFFF_FFFC, 32'h100, 1'b1, 1'b1, 1'b1, 32'hFC);
    step();
    bus.res_valid = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (bus.redirect_valid !== e.v || bus.redirect_pc !== e.pc || e.v !== 1'b0) begin
      errors++;
      $display("FAIL reg_hold: got v=%0b pc=%h, want v=%0b pc=%h", bus.redirect_valid, bus.redirect_pc, e.v, e.pc);
    end
    bus.fetch_pc = 9'h084;
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'hFC) begin
      errors++;
      $display("FAIL reg_pred: got t=%0b tgt=%h, want t=1 tgt=fc", bus.pred_taken, bus.pred_target);
    end
  endtask

  // Back-to-back resolves on the WT entry at 0x040
  task automatic test_counter();
    logic outcome [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic want    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t e;
    bus.fetch_pc = 9'h040;
    for (int i = 0; i < 7; i++) begin
      drive_res(9'h040, 32'h20, 32'h0, 1'b0, outcome[i], m_pred_taken(9'h040), 32'h60);
      step();
      e = sb_q.pop_front();
      checks++;
      if (bus.redirect_valid !== e.v || bus.redirect_pc !== e.pc) begin
        errors++;
        $display("FAIL ctr_redirect[%0d]: got v=%0b pc=%h, want v=%0b pc=%h", i, bus.redirect_valid, bus.redirect_pc, e.v, e.pc);
      end
      checks++;
      if (bus.pred_taken !== want[i] || bus.pred_taken !== m_pred_taken(9'h040) ||
          bus.pred_target !== m_pred_target(9'h040)) begin
        errors++;
        $display("FAIL ctr_pred[%0d]: got t=%0b tgt=%h, want t=%0b tgt=%h", i, bus.pred_taken, bus.pred_target, want[i], m_pred_target(9'h040));
      end
    end
    bus.res_valid = 1'b0;
  endtask

  task automatic test_same_cycle();
    exp_t e;
    bus.fetch_pc = 9'h060;
    drive_res(9'h060, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h64) begin
      errors++;
      $display("FAIL same_cycle_old: got t=%0b tgt=%h, want t=0 tgt=64", bus.pred_taken, bus.pred_target);
    end
    step();
    bus.res_valid = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (bus.redirect_valid !== e.v || bus.redirect_pc !== e.pc || e.pc !== 32'h70) begin
      errors++;
      $display("FAIL same_cycle_redirect: got v=%0b pc=%h, want v=%0b pc=%h", bus.redirect_valid, bus.redirect_pc, e.v, e.pc);
    end
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h70) begin
      errors++;
      $display("FAIL same_cycle_new: got t=%0b tgt=%h, want t=1 tgt=70", bus.pred_taken, bus.pred_target);
    end
    bus.fetch_pc = 9'h040;
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h44) begin
      errors++;
      $display("FAIL same_cycle_evict: got t=%0b tgt=%h, want t=0 tgt=44", bus.pred_taken, bus.pred_target);
    end
  endtask

  task automatic test_reset_mispredict();
    exp_t        e;
    logic [8:0]  pcs [3] = '{9'h040, 9'h060, 9'h084};
    logic [8:0]  p;
    reset = 1'b1;
    drive_res(9'h040, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    bus.res_valid = 1'b0;
    reset = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (bus.redirect_valid !== e.v || bus.redirect_pc !== e.pc) begin
      errors++;
      $display("FAIL rst_mis_redirect: got v=%0b pc=%h, want v=%0b pc=%h", bus.redirect_valid, bus.redirect_pc, e.v, e.pc);
    end
    for (int i = 0; i < 3; i++) begin
      p = pcs[i];
      bus.fetch_pc = p;
      #1;
      checks++;
      if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'(p) + 32'd4) begin
        errors++;
        $display("FAIL rst_mis_entry[%0d]: got t=%0b tgt=%h, want t=0 tgt=%h", i, bus.pred_taken, bus.pred_target, 32'(p) + 32'd4);
      end
    end
    step();
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_mis_idle: got v=%0b pc=%h, want v=0 pc=0", bus.redirect_valid, bus.redirect_pc);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_reg_target();
    test_counter();
    test_same_cycle();
    test_reset_mispredict();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
